data_bus_decoder: RTL and testbench
===================================

// Module: data_bus_decoder
// PURPOSE
// - Parametrised data-side interconnect between the CPU data port and NUM_SLAVES memory-mapped slaves.
// - Sits in the SoC top between my_mips_cpu's ram_* port and the data RAM plus peripherals.
// - Decodes each access to one slave by base/mask and forwards it, then stalls the CPU until the slave acks.
// - Reports a one-cycle bus error on an unmapped address or on slave timeout.
// PARAMETERS
// NUM_SLAVES   4                         number of slave ports (1..8)
// ADDR_W       32                        address width
// DATA_W       32                        data width; SEL_W = DATA_W/8
// SLAVE_BASE   {32'h3000_0000,...}       packed NUM_SLAVES*ADDR_W base addresses, slave 0 in LSBs
// SLAVE_MASK   {32'hF000_0000,...}       packed NUM_SLAVES*ADDR_W compare masks, slave 0 in LSBs
// TIMEOUT      16                        max ACCESS cycles without ack before error (>=1)
// PORTS
// clk         in   1                clock, all state on rising edge
// rst         in   1                asynchronous, active-low reset
// m_ce_i      in   1                CPU access request
// m_we_i      in   1                1=write, 0=read
// m_addr_i    in   ADDR_W           CPU address
// m_sel_i     in   SEL_W            byte enables
// m_data_i    in   DATA_W           CPU write data
// m_data_o    out  DATA_W           read data, valid in DONE cycle
// m_stall_o   out  1                CPU must hold the request and freeze the pipeline
// m_err_o     out  1                one-cycle bus error strobe
// s_ce_o      out  NUM_SLAVES       one-hot slave select
// s_we_o      out  1                latched write enable (shared)
// s_addr_o    out  ADDR_W           latched address (shared)
// s_sel_o     out  SEL_W            latched byte enables (shared)
// s_data_o    out  DATA_W           latched write data (shared)
// s_data_i    in   NUM_SLAVES*DATA_W  slave read data, slave i in slice i
// s_ack_i     in   NUM_SLAVES       slave completion, 1 cycle
// BEHAVIOUR
// - Decode: hit[i] = ((m_addr_i & MASK[i]) == BASE[i]). Lowest index wins on overlap; no hit = decode miss.
// - FSM states: IDLE, ACCESS, DONE, ERR. Reset (rst=0) takes effect immediately, including mid-access:
//   state=IDLE, counter=0, and all outputs 0 (s_ce_o=0, m_stall_o=0, m_err_o=0, m_data_o=0).
// - IDLE:
//   - m_stall_o = m_ce_i, combinational, in the request cycle.
//   - m_ce_i & hit: latch we/addr/sel/data and slave index, then go to ACCESS.
//   - m_ce_i & miss: go to ERR.
//   - Any s_ack_i seen in IDLE is ignored.
// - ACCESS:
//   - s_ce_o[idx]=1; shared s_* outputs carry the latched values; m_stall_o=1.
//   - The counter increments each cycle.
//   - s_ack_i[idx]=1: capture the s_data_i slice idx (reads) or 0 (writes) into the read register, then go to DONE.
//   - Acks from other slaves are ignored.
//   - No ack after TIMEOUT ACCESS cycles: go to ERR. An ack in the TIMEOUT-th cycle wins over timeout.
// - DONE: exactly 1 cycle.
//   - m_stall_o=0, m_data_o = captured data, s_ce_o=0, then back to IDLE.
//   - m_ce_i is ignored in DONE; the CPU advances on this cycle.
// - ERR: exactly 1 cycle.
//   - m_err_o=1, m_stall_o=0, m_data_o=0, s_ce_o=0, then back to IDLE.
//   - No slave sees a strobe for a decode miss.
// - Latency: a request with the ack in the first ACCESS cycle stalls 2 cycles; data is returned in cycle 3.
//   Each extra wait state adds 1 cycle.
// - m_data_o holds its value only in DONE; it is 0 in every other state.
// - The counter clears on entering ACCESS.
// TESTING
// - Read slave 1 (base 0x1000_0000, mask 0xF000_0000), ack in the 1st ACCESS cycle with 0xDEADBEEF:
//   stall=1 for 2 cycles, then m_data_o=0xDEADBEEF in DONE and s_ce_o=4'b0010 for exactly 1 cycle.
// - Write 0x1234_5678 with sel=4'b0011 to slave 0, ack after 3 wait cycles:
//   s_data_o/s_sel_o stable through ACCESS, 5 stall cycles, m_err_o=0.
// - Access to unmapped 0xF000_0000: no s_ce_o bit, 1 stall cycle, then m_err_o=1 for 1 cycle.
// - Slave never acks with TIMEOUT=16: 16 ACCESS cycles, then ERR. Repeat with the ack on cycle 16: DONE, no error.
// - Back-to-back reads to slaves 0 then 2: second request accepted in the IDLE after DONE;
//   a stray s_ack_i[3] during ACCESS is ignored.
// - Assert rst=0 mid-ACCESS: s_ce_o and m_stall_o drop to 0 immediately; after release the FSM is in IDLE.

Source files
------------

// File: rtl/data_bus_decoder_if.sv
// rtl/data_bus_decoder_if.sv - CPU data-port bundle between the CPU and the data bus decoder
interface data_bus_decoder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m_ce_i;
    logic                  m_we_i;
    logic [ADDR_W-1:0]     m_addr_i;
    logic [DATA_W/8-1:0]   m_sel_i;
    logic [DATA_W-1:0]     m_data_i;
    logic [DATA_W-1:0]     m_data_o;
    logic                  m_stall_o;
    logic                  m_err_o;

    // CPU side: issues requests, consumes data/stall/error
    modport master (
        output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
        input  m_data_o, m_stall_o, m_err_o
    );

    // Decoder side: accepts requests, returns data/stall/error
    modport slave (
        input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
        output m_data_o, m_stall_o, m_err_o
    );
endinterface

// File: rtl/data_bus_decoder.sv
// rtl/data_bus_decoder.sv - CPU data-port to NUM_SLAVES slave decoder with stall, timeout and bus error
module data_bus_decoder #(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       ADDR_W     = 32,
    parameter int                       DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int                       TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    data_bus_decoder_if.slave            cpu,
    output logic [NUM_SLAVES-1:0]        s_ce_o,
    output logic                         s_we_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic [DATA_W-1:0]            s_data_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [NUM_SLAVES-1:0]   s_ce_q;
    logic                    err_q;
    logic [DATA_W-1:0]       rdata_q;

    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic [DATA_W-1:0]       ack_slice;

    // Address decode; scanning downwards lets the lowest matching index win
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu.m_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign ack_slice = s_data_i[int'(idx_q)*DATA_W +: DATA_W];

    // Transaction FSM: latch request, strobe the selected slave, wait for ack or timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            s_ce_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    if (cpu.m_ce_i) begin
                        if (hit) begin
                            idx_q   <= hit_idx;
                            we_q    <= cpu.m_we_i;
                            addr_q  <= cpu.m_addr_i;
                            sel_q   <= cpu.m_sel_i;
                            wdata_q <= cpu.m_data_i;
                            cnt_q   <= '0;
                            s_ce_q  <= NUM_SLAVES'(1) << hit_idx;
                            state_q <= ACCESS;
                        end else begin
                            // decode miss goes straight to the error cycle, no slave strobe
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                ACCESS: begin
                    if (s_ack_i[idx_q]) begin
                        // an ack in the last allowed cycle still completes normally
                        rdata_q <= we_q ? '0 : ack_slice;
                        s_ce_q  <= '0;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        s_ce_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    rdata_q <= '0;
                    state_q <= IDLE;
                end
                ERR: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational in the request cycle so the CPU freezes immediately
    assign cpu.m_stall_o = (state_q == ACCESS) | ((state_q == IDLE) & cpu.m_ce_i & rst);
    assign cpu.m_err_o   = err_q;
    assign cpu.m_data_o  = rdata_q;

    assign s_ce_o   = s_ce_q;
    assign s_we_o   = we_q;
    assign s_addr_o = addr_q;
    assign s_sel_o  = sel_q;
    assign s_data_o = wdata_q;

endmodule

// File: tb/tb_data_bus_decoder.sv
// tb/tb_data_bus_decoder.sv - scoreboard testbench for data_bus_decoder
module tb_data_bus_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   s_ce_o;
    logic         s_we_o;
    logic [31:0]  s_addr_o;
    logic [3:0]   s_sel_o;
    logic [31:0]  s_data_o;
    logic [127:0] s_data_i;
    logic [3:0]   s_ack_i;

    data_bus_decoder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_bus_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (bus.slave),
        .s_ce_o   (s_ce_o),
        .s_we_o   (s_we_o),
        .s_addr_o (s_addr_o),
        .s_sel_o  (s_sel_o),
        .s_data_o (s_data_o),
        .s_data_i (s_data_i),
        .s_ack_i  (s_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          stalls;
        logic [3:0]  ce;
        int          ce_cycles;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   in_reset = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares shared slave outputs each strobe cycle and pops on each response
    int         m_stalls = 0;
    int         m_ce_cycles = 0;
    logic [3:0] m_ce_or = '0;
    logic       stall_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (in_reset) begin
            m_stalls    = 0;
            m_ce_cycles = 0;
            m_ce_or     = '0;
            stall_prev  = 1'b0;
        end else begin
            if (s_ce_o != 4'b0) begin
                m_ce_cycles++;
                m_ce_or |= s_ce_o;
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", 32'(s_ce_o), 32'h0);
                end else begin
                    chk("s_we_o",   32'(s_we_o),  32'(sbq[0].we));
                    chk("s_addr_o", s_addr_o,     sbq[0].addr);
                    chk("s_sel_o",  32'(s_sel_o), 32'(sbq[0].sel));
                    chk("s_data_o", s_data_o,     sbq[0].wdata);
                end
            end
            if (bus.m_stall_o) m_stalls++;
            if (bus.m_err_o || (stall_prev && !bus.m_stall_o)) begin
                chk("response_expected", 32'(sbq.size() != 0), 32'h1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("m_err_o",      32'(bus.m_err_o), 32'(e.err));
                    chk("m_data_o",     bus.m_data_o,     e.data);
                    chk("stall_cycles", 32'(m_stalls),    32'(e.stalls));
                    chk("s_ce_o_seen",  32'(m_ce_or),     32'(e.ce));
                    chk("s_ce_cycles",  32'(m_ce_cycles), 32'(e.ce_cycles));
                end
                m_stalls    = 0;
                m_ce_cycles = 0;
                m_ce_or     = '0;
            end else begin
                chk("m_data_o_idle", bus.m_data_o, 32'h0);
            end
            stall_prev = bus.m_stall_o;
        end
    end

    // One CPU transaction; the slave acks on access cycle ack_cycle (0 = never)
    task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wdata, input int ack_slave, input int ack_cycle,
                        input logic [31:0] rdata, input bit stray, input bit early, input bit in_done,
                        input logic exp_err, input logic [31:0] exp_data, input int exp_stalls,
                        input logic [3:0] exp_ce, input int exp_ce_cycles);
        exp_t e;
        e.err = exp_err; e.data = exp_data; e.stalls = exp_stalls; e.ce = exp_ce;
        e.ce_cycles = exp_ce_cycles; e.we = we; e.addr = addr; e.sel = sel; e.wdata = wdata;
        sbq.push_back(e);
        if (!in_done) begin
            @(posedge clk); #1;
        end
        bus.m_ce_i   = 1'b1;
        bus.m_we_i   = we;
        bus.m_addr_i = addr;
        bus.m_sel_i  = sel;
        bus.m_data_i = wdata;
        if (in_done) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        for (int k = 1; k <= exp_ce_cycles; k++) begin
            if (k == ack_cycle && ack_slave >= 0) begin
                s_ack_i[ack_slave] = 1'b1;
                s_data_i[ack_slave*32 +: 32] = rdata;
            end
            if (stray && k == 1) s_ack_i[3] = 1'b1;
            @(posedge clk); #1;
            s_ack_i = 4'b0;
        end
        if (!early) begin
            bus.m_ce_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_data_i     = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        s_ack_i      = 4'b0;
        bus.m_ce_i   = 1'b1;
        bus.m_we_i   = 1'b0;
        bus.m_addr_i = 32'h1000_0000;
        bus.m_sel_i  = 4'hF;
        bus.m_data_i = 32'h0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_s_ce_o",  32'(s_ce_o),        32'h0);
        chk("reset_stall",   32'(bus.m_stall_o), 32'h0);
        chk("reset_err",     32'(bus.m_err_o),   32'h0);
        chk("reset_data",    bus.m_data_o,       32'h0);
        repeat (3) @(posedge clk);
        #1;
        bus.m_ce_i = 1'b0;
        rst        = 1'b1;
        in_reset   = 1'b0;

        // stray acks while idle must not start anything
        @(posedge clk); #1;
        s_ack_i = 4'b1111;
        @(posedge clk); #1;
        s_ack_i = 4'b0;

        // read slave 1, ack in first access cycle
        xfer(32'h1000_0000, 1'b0, 4'hF, 32'h0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0,
             1'b0, 32'hDEAD_BEEF, 2, 4'b0010, 1);
        // write slave 0, three wait cycles; write returns zero data
        xfer(32'h0000_0100, 1'b1, 4'b0011, 32'h1234_5678, 0, 4, 32'h5555_AAAA, 0, 0, 0,
             1'b0, 32'h0, 5, 4'b0001, 4);
        // unmapped address
        xfer(32'hF000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, 0, 0, 0,
             1'b1, 32'h0, 1, 4'b0000, 0);
        // slave 3 never acks: 16 access cycles then error
        xfer(32'h3000_0010, 1'b0, 4'hF, 32'h0, 3, 0, 32'h0, 0, 0, 0,
             1'b1, 32'h0, 17, 4'b1000, 16);
        // ack on the 16th access cycle wins over the timeout
        xfer(32'h3000_0010, 1'b0, 4'hF, 32'h0, 3, 16, 32'hCAFE_F00D, 0, 0, 0,
             1'b0, 32'hCAFE_F00D, 17, 4'b1000, 16);
        // back-to-back: slave 0 then slave 2, next request presented during DONE
        xfer(32'h0000_0008, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0123_4567, 0, 1, 0,
             1'b0, 32'h0123_4567, 2, 4'b0001, 1);
        xfer(32'h2000_0004, 1'b0, 4'b1100, 32'h0, 2, 2, 32'h89AB_CDEF, 1, 0, 1,
             1'b0, 32'h89AB_CDEF, 3, 4'b0100, 2);

        // reset in the middle of an access
        begin
            exp_t e;
            e.err = 1'b0; e.data = 32'h0; e.stalls = 0; e.ce = 4'b0; e.ce_cycles = 0;
            e.we = 1'b0; e.addr = 32'h1000_0040; e.sel = 4'hF; e.wdata = 32'h0;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        bus.m_ce_i   = 1'b1;
        bus.m_we_i   = 1'b0;
        bus.m_addr_i = 32'h1000_0040;
        bus.m_sel_i  = 4'hF;
        bus.m_data_i = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_strobe", 32'(s_ce_o), 32'h2);
        rst      = 1'b0;
        in_reset = 1'b1;
        #1;
        chk("midreset_s_ce_o", 32'(s_ce_o),        32'h0);
        chk("midreset_stall",  32'(bus.m_stall_o), 32'h0);
        chk("midreset_err",    32'(bus.m_err_o),   32'h0);
        sbq.delete();
        bus.m_ce_i = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b1;
        in_reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_stall", 32'(bus.m_stall_o), 32'h0);
        chk("post_reset_s_ce",  32'(s_ce_o),        32'h0);
        // FSM must be back in IDLE: a normal read has the minimum latency
        xfer(32'h1000_0040, 1'b0, 4'hF, 32'h0, 1, 1, 32'h5A5A_0F0F, 0, 0, 0,
             1'b0, 32'h5A5A_0F0F, 2, 4'b0010, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
